// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs BYTES_PER_WORD bytes (LSB byte first) into a word
// and offers it to the cpu with a valid/ack handshake.
module uart_word_rx #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_BITS   = 40
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rx,
  input  logic                        ack,
  output logic [8*BYTES_PER_WORD-1:0] data_out,
  output logic                        valid,
  output logic                        busy,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW     = $clog2(TO_CYC + 1);
  localparam int IW     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TO_END   = CW'(TO_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                         state, state_nxt;
  logic                           rx_m, rx_s;
  logic [CW-1:0]                  cnt, tcnt;
  logic [2:0]                     bit_idx;
  logic [7:0]                     shreg;
  logic [IW-1:0]                  byte_idx;
  logic [BYTES_PER_WORD-1:0][7:0] wbuf;
  logic                           word_done;
  logic                           shift_en, stop_smp;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // cnt restarts on every state change and on each data bit boundary
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || shift_en || state == IDLE) cnt <= '0;
      else                                                  cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    stop_smp  = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (cnt == HALF_END) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (cnt == BIT_END) begin
               shift_en = 1'b1;
               if (bit_idx == 3'd7) state_nxt = STOP;
             end
      STOP:  if (cnt == BIT_END) begin
               stop_smp  = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_idx   <= '0;
      shreg     <= '0;
      byte_idx  <= '0;
      wbuf      <= '0;
      word_done <= 1'b0;
      tcnt      <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      word_done <= 1'b0;

      if (state == START && state_nxt == DATA) bit_idx <= '0;
      if (shift_en) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      if (stop_smp) begin
        if (rx_s) begin
          wbuf[byte_idx] <= shreg;
          if (byte_idx == LAST_IDX) begin
            byte_idx  <= '0;
            word_done <= 1'b1;
          end else begin
            byte_idx <= byte_idx + IW'(1);
          end
        end else begin
          frame_err <= 1'b1;
          byte_idx  <= '0;
        end
      end

      // A partial word left idle too long is silently abandoned
      if (state == IDLE && byte_idx != '0) begin
        if (tcnt == TO_END) begin
          tcnt     <= '0;
          byte_idx <= '0;
        end else begin
          tcnt <= tcnt + CW'(1);
        end
      end else begin
        tcnt <= '0;
      end

      if (valid && ack) valid <= 1'b0;
      if (word_done) begin
        if (!valid || ack) begin
          data_out <= wbuf;
          valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: directed step table, hand sequences for glitch/reset,
// then random byte/ack/idle traffic checked against a word-level model.
module tb_uart_word_rx;
  localparam int CPB = 8;
  localparam int BPW = 4;
  localparam int TOB = 40;
  localparam int GAP = 8;

  logic        clock = 1'b0, reset = 1'b1, rx = 1'b1, ack = 1'b0;
  logic [31:0] data_out;
  logic        valid, busy, frame_err, overrun;

  uart_word_rx #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(BPW), .TIMEOUT_BITS(TOB)) dut (
    .clock(clock), .reset(reset), .rx(rx), .ack(ack), .data_out(data_out),
    .valid(valid), .busy(busy), .frame_err(frame_err), .overrun(overrun));

  always #5 clock = ~clock;

  int   vectors = 0, errors = 0;
  int   fe_cnt = 0, ovr_cnt = 0, dbl_cnt = 0;
  logic fe_q = 1'b0, ovr_q = 1'b0;

  always @(posedge clock) begin
    #1;
    if (frame_err) fe_cnt++;
    if (overrun) ovr_cnt++;
    if ((frame_err && fe_q) || (overrun && ovr_q)) dbl_cnt++;
    fe_q  = frame_err;
    ovr_q = overrun;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0; cyc(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; cyc(CPB); end
    rx = stop; cyc(CPB);
    rx = 1'b1;
  endtask

  typedef enum int {OP_BYTE, OP_BAD, OP_IDLE, OP_ACK, OP_ACK_ON, OP_ACK_OFF} op_e;
  typedef struct {
    op_e         op;
    logic [7:0]  b;
    int          n;
    logic [31:0] exp_data;
    logic        exp_valid;
    int          exp_fe;
    int          exp_ovr;
  } step_t;

  step_t tbl[$];

  function automatic void add(op_e op, logic [7:0] b, int n, logic [31:0] d, logic v, int fe, int ov);
    step_t s;
    s.op = op; s.b = b; s.n = n; s.exp_data = d; s.exp_valid = v; s.exp_fe = fe; s.exp_ovr = ov;
    tbl.push_back(s);
  endfunction

  task automatic apply_step(input step_t s);
    case (s.op)
      OP_BYTE: begin send_frame(s.b, 1'b1); cyc(GAP); end
      OP_BAD:  begin send_frame(s.b, 1'b0); cyc(GAP); end
      OP_IDLE: for (int i = 0; i < s.n; i++) begin
                 cyc(1);
                 chk("idle_valid", {31'd0, valid}, {31'd0, s.exp_valid});
                 chk("idle_data", data_out, s.exp_data);
               end
      OP_ACK:     begin ack = 1'b1; cyc(1); ack = 1'b0; cyc(2); end
      OP_ACK_ON:  begin ack = 1'b1; cyc(2); end
      OP_ACK_OFF: begin ack = 1'b0; cyc(2); end
      default: ;
    endcase
    chk("step_data", data_out, s.exp_data);
    chk("step_valid", {31'd0, valid}, {31'd0, s.exp_valid});
    chk("step_fe", fe_cnt, s.exp_fe);
    chk("step_ovr", ovr_cnt, s.exp_ovr);
  endtask

  // Word-level reference: bytes land in slots, a full word either loads or overruns
  logic [7:0]  m_buf [BPW];
  int          m_idx, m_fe, m_ovr;
  logic        m_valid;
  logic [31:0] m_data;

  function automatic void m_byte(logic [7:0] b, logic stop_ok);
    logic [31:0] w;
    if (!stop_ok) begin m_fe++; m_idx = 0; return; end
    m_buf[m_idx] = b;
    m_idx++;
    if (m_idx == BPW) begin
      m_idx = 0;
      w = 0;
      for (int k = 0; k < BPW; k++) w += 32'(m_buf[k]) << (8 * k);
      if (!m_valid) begin m_data = w; m_valid = 1'b1; end
      else m_ovr++;
    end
  endfunction

  initial begin
    int          base_fe, base_ovr, r;
    logic [7:0]  b;
    logic        bsy_seen;
    step_t       s;

    cyc(3);
    chk("rst_data", data_out, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_fe", {31'd0, frame_err}, 32'h0);
    chk("rst_ovr", {31'd0, overrun}, 32'h0);
    reset = 1'b0;
    cyc(5);

    // short low glitch must be rejected without recording anything
    rx = 1'b0; cyc(2); rx = 1'b1;
    bsy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin cyc(1); if (busy) bsy_seen = 1'b1; end
    cyc(20);
    chk("glitch_busy_seen", {31'd0, bsy_seen}, 32'h1);
    chk("glitch_busy", {31'd0, busy}, 32'h0);
    chk("glitch_valid", {31'd0, valid}, 32'h0);
    chk("glitch_fe", fe_cnt, 0);
    chk("glitch_ovr", ovr_cnt, 0);

    add(OP_BYTE, 8'h78, 0, 32'h0, 1'b0, 0, 0);
    add(OP_BYTE, 8'h56, 0, 32'h0, 1'b0, 0, 0);
    add(OP_BYTE, 8'h34, 0, 32'h0, 1'b0, 0, 0);
    add(OP_BYTE, 8'h12, 0, 32'h12345678, 1'b1, 0, 0);
    add(OP_IDLE, 8'h00, 100, 32'h12345678, 1'b1, 0, 0);
    add(OP_ACK, 8'h00, 0, 32'h12345678, 1'b0, 0, 0);
    add(OP_BYTE, 8'h11, 0, 32'h12345678, 1'b0, 0, 0);
    add(OP_BAD, 8'h22, 0, 32'h12345678, 1'b0, 1, 0);
    add(OP_BYTE, 8'hEF, 0, 32'h12345678, 1'b0, 1, 0);
    add(OP_BYTE, 8'hBE, 0, 32'h12345678, 1'b0, 1, 0);
    add(OP_BYTE, 8'hAD, 0, 32'h12345678, 1'b0, 1, 0);
    add(OP_BYTE, 8'hDE, 0, 32'hDEADBEEF, 1'b1, 1, 0);
    add(OP_ACK, 8'h00, 0, 32'hDEADBEEF, 1'b0, 1, 0);
    add(OP_BYTE, 8'h01, 0, 32'hDEADBEEF, 1'b0, 1, 0);
    add(OP_BYTE, 8'h02, 0, 32'hDEADBEEF, 1'b0, 1, 0);
    add(OP_BYTE, 8'h03, 0, 32'hDEADBEEF, 1'b0, 1, 0);
    add(OP_BYTE, 8'h04, 0, 32'h04030201, 1'b1, 1, 0);
    add(OP_BYTE, 8'h05, 0, 32'h04030201, 1'b1, 1, 0);
    add(OP_BYTE, 8'h06, 0, 32'h04030201, 1'b1, 1, 0);
    add(OP_BYTE, 8'h07, 0, 32'h04030201, 1'b1, 1, 0);
    add(OP_BYTE, 8'h08, 0, 32'h04030201, 1'b1, 1, 1);
    add(OP_BYTE, 8'h05, 0, 32'h04030201, 1'b1, 1, 1);
    add(OP_BYTE, 8'h06, 0, 32'h04030201, 1'b1, 1, 1);
    add(OP_BYTE, 8'h07, 0, 32'h04030201, 1'b1, 1, 1);
    add(OP_ACK_ON, 8'h00, 0, 32'h04030201, 1'b0, 1, 1);
    add(OP_BYTE, 8'h08, 0, 32'h08070605, 1'b0, 1, 1);
    add(OP_ACK_OFF, 8'h00, 0, 32'h08070605, 1'b0, 1, 1);
    add(OP_BYTE, 8'hAA, 0, 32'h08070605, 1'b0, 1, 1);
    add(OP_BYTE, 8'hBB, 0, 32'h08070605, 1'b0, 1, 1);
    add(OP_IDLE, 8'h00, 400, 32'h08070605, 1'b0, 1, 1);
    add(OP_BYTE, 8'h0D, 0, 32'h08070605, 1'b0, 1, 1);
    add(OP_BYTE, 8'hF0, 0, 32'h08070605, 1'b0, 1, 1);
    add(OP_BYTE, 8'hFE, 0, 32'h08070605, 1'b0, 1, 1);
    add(OP_BYTE, 8'hCA, 0, 32'hCAFEF00D, 1'b1, 1, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      s = tbl[i];
      apply_step(s);
    end

    // reset in the middle of the second byte's data bits
    send_frame(8'h01, 1'b1); cyc(GAP);
    rx = 1'b0; cyc(CPB);
    rx = 1'b1; cyc(CPB);
    rx = 1'b0; cyc(CPB + 3);
    reset = 1'b1; rx = 1'b1; cyc(1);
    chk("midrst_data", data_out, 32'h0);
    chk("midrst_valid", {31'd0, valid}, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'h0);
    chk("midrst_fe", {31'd0, frame_err}, 32'h0);
    chk("midrst_ovr", {31'd0, overrun}, 32'h0);
    reset = 1'b0; cyc(50);
    base_fe = fe_cnt;
    send_frame(8'hEF, 1'b1); cyc(GAP);
    send_frame(8'hCD, 1'b1); cyc(GAP);
    send_frame(8'hAB, 1'b1); cyc(GAP);
    send_frame(8'h89, 1'b1); cyc(GAP);
    chk("postrst_data", data_out, 32'h89ABCDEF);
    chk("postrst_valid", {31'd0, valid}, 32'h1);
    chk("postrst_fe", fe_cnt, base_fe);

    // random traffic against the model, from a fresh reset
    reset = 1'b1; cyc(2); reset = 1'b0; cyc(5);
    m_idx = 0; m_fe = 0; m_ovr = 0; m_valid = 1'b0; m_data = 32'h0;
    base_fe = fe_cnt; base_ovr = ovr_cnt;
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 99));
      b = 8'($urandom);
      if (r < 65) begin
        send_frame(b, 1'b1); m_byte(b, 1'b1);
      end else if (r < 75) begin
        send_frame(b, 1'b0); m_byte(b, 1'b0);
      end else if (r < 90) begin
        ack = 1'b1; cyc(1); ack = 1'b0;
        m_valid = 1'b0;
      end else begin
        cyc(400);
        m_idx = 0;
      end
      cyc(int'($urandom_range(GAP, 30)));
      chk("rnd_data", data_out, m_data);
      chk("rnd_valid", {31'd0, valid}, {31'd0, m_valid});
      chk("rnd_fe", fe_cnt - base_fe, m_fe);
      chk("rnd_ovr", ovr_cnt - base_ovr, m_ovr);
    end

    chk("no_back_to_back_pulses", dbl_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
